fifo2axis: RTL and testbench
============================

Name: fifo2axis

Overview:
- Transmit-side counterpart of the stream-to-FIFO capture block.
- Collects words written by an upstream FIFO/producer interface into an internal packet buffer, then emits them as an AXI4-Stream master packet with tvalid/tready/tlast.
- A packet is either PKT_LEN words or a shorter packet terminated by a flush request.
- Sits between internal processing logic and a downstream AXI-Stream slave such as a DMA or an interconnect.

Parameters:
DATA_WIDTH, 32, width of din and m_axis_tdata
PKT_LEN, 4, maximum words per packet (>=1); buffer depth; index width is max(1,$clog2(PKT_LEN+1))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  DATA_WIDTH  word from producer
din_valid  input  1  producer write strobe
din_ready  output  1  block accepts din this cycle
flush  input  1  terminate current partial packet
m_axis_tdata  output  DATA_WIDTH  stream data (registered)
m_axis_tvalid  output  1  stream valid (registered)
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  final beat of packet (registered)
busy  output  1  high while a packet is being streamed
pkt_sent  output  1  one-cycle pulse after the final beat handshakes

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; wr_cnt=0; rd_idx=0; pkt_len_r=0.
  - m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, pkt_sent=0.
  - Buffer contents are don't-care.
- States: IDLE, FILL, STREAM.
- IDLE: din_ready=0; moves to FILL unconditionally on the next clock. This gives exactly one dead cycle after reset release.
- FILL:
  - din_ready=1.
  - Accept = din_valid && din_ready. On accept: buf[wr_cnt]<=din; wr_cnt++.
  - End-of-packet condition: (accept && wr_cnt+1==PKT_LEN) || (flush && (wr_cnt>0 || accept)).
  - On end-of-packet:
    - pkt_len_r <= number of words held including this cycle's accept.
    - wr_cnt<=0; rd_idx<=0.
    - m_axis_tdata<=word 0 (din if wr_cnt was 0 and accepting, else buf[0]).
    - m_axis_tvalid<=1; m_axis_tlast<=(pkt_len==1); state<=STREAM.
  - flush with wr_cnt==0 and no accept: ignored, no empty packet.
- STREAM:
  - din_ready=0; busy=1; din_valid and flush are ignored (not queued).
  - Beat = m_axis_tvalid && m_axis_tready.
  - No beat: tdata, tvalid and tlast hold stable (AXIS rule).
  - Beat, not last: rd_idx++; next cycle tdata=buf[rd_idx+1], tlast=(rd_idx+2==pkt_len_r). Back-to-back beats are possible every cycle (no bubbles).
  - Beat with tlast=1: next cycle tvalid=0, tlast=0, tdata=0, pkt_sent=1 for one cycle, state=FILL. din_ready is high in that same cycle.
- busy = (state==STREAM); din_ready = (state==FILL); both decoded from state.
- Latency: the PKT_LEN-th accept at cycle N gives tvalid high at N+1.
- Best case, one packet plus refill takes PKT_LEN fill cycles + PKT_LEN beats; there is no overlap of fill and stream.
- Reset mid-packet (FILL or STREAM): the partial or in-flight packet is discarded; tvalid drops immediately (asynchronously).
- tdata never shows X; idle value is 0.
- No backpressure to the producer beyond din_ready; producer must honour din_ready.

Test Plan:
1. Reset release, then din 0x11,0x22,0x33,0x44 on consecutive cycles, tready=1 -> din_ready high from 2nd cycle after release; beats 0x11..0x44 on 4 consecutive cycles; tlast only with 0x44; pkt_sent pulse one cycle later; din_ready high again.
2. Same packet with tready toggling 1,0,0,1,0,1,1 -> each word is held stable while tready=0; order 0x11..0x44 preserved; exactly 4 beats; tlast on 0x44.
3. Write 0xA1,0xA2, then flush alone -> 2-beat packet 0xA1,0xA2, tlast on 0xA2. Then din 0xB1 with flush in the same cycle -> 1-beat packet 0xB1, tlast=1.
4. flush with empty buffer and din_valid=0 -> no tvalid, state stays FILL. Then din_valid=1 during STREAM -> word 0xDEAD is dropped and never appears on m_axis_tdata.
5. Assert rst_n=0 after the 2nd beat of a 4-word packet -> tvalid/tlast/tdata go to 0 asynchronously. After release, a new packet 0x01..0x04 streams correctly with no stale words.
6. PKT_LEN=1 build -> every accepted din produces a single beat with tlast=1 and a pkt_sent pulse.

Source files
------------

// File: rtl/fifo2axis.sv
// fifo2axis: buffers producer words into a packet and streams it out as an AXI4-Stream master
module fifo2axis #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  pkt_sent
);
  localparam int IW = $clog2(PKT_LEN + 1);
  localparam int AW = (PKT_LEN < 2) ? 1 : $clog2(PKT_LEN);
  localparam logic [IW-1:0] LEN = IW'(PKT_LEN);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  state_t r_state, w_state_nxt;
  logic [IW-1:0] r_wr_cnt, r_rd_idx, r_pkt_len, w_len, w_rd_nxt;
  logic [DATA_WIDTH-1:0] r_buf [0:(1<<AW)-1];
  logic [DATA_WIDTH-1:0] r_tdata;
  logic r_tvalid, r_tlast, r_pkt_sent;
  logic w_accept, w_eop, w_beat;
  assign din_ready     = (r_state == FILL);
  assign busy          = (r_state == STREAM);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign pkt_sent      = r_pkt_sent;
  assign w_accept      = din_valid && din_ready;
  assign w_len         = r_wr_cnt + IW'(w_accept);
  // w_len is the word count including this cycle's accept, so a nonzero value means flush has data to send
  assign w_eop         = din_ready && ((w_accept && w_len == LEN) || (flush && w_len != '0));
  assign w_beat        = r_tvalid && m_axis_tready;
  assign w_rd_nxt      = r_rd_idx + IW'(1);
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = FILL;
    else if (w_eop) w_state_nxt = STREAM;
    else if (w_beat && r_tlast) w_state_nxt = FILL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk)
    if (w_accept) r_buf[r_wr_cnt[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_cnt   <= '0;
      r_rd_idx   <= '0;
      r_pkt_len  <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_pkt_sent <= 1'b0;
    end else begin
      r_pkt_sent <= w_beat && r_tlast;
      r_wr_cnt   <= w_eop ? '0 : w_len;
      if (w_eop) begin
        r_pkt_len <= w_len;
        r_rd_idx  <= '0;
        r_tdata   <= (r_wr_cnt == '0 && w_accept) ? din : r_buf[0];
        r_tvalid  <= 1'b1;
        r_tlast   <= (w_len == IW'(1));
      end else if (w_beat && r_tlast) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tdata  <= '0;
      end else if (w_beat) begin
        r_rd_idx <= w_rd_nxt;
        r_tdata  <= r_buf[w_rd_nxt[AW-1:0]];
        r_tlast  <= (w_rd_nxt + IW'(1) == r_pkt_len);
      end
    end
endmodule

// File: tb/tb_fifo2axis.sv
// tb_fifo2axis: randomized and directed checks of fifo2axis against a queue-based packet model
module tb_fifo2axis;
  localparam int DW = 32;
  localparam int PL = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] din = '0, d1_din = '0;
  logic din_valid = 1'b0, flush = 1'b0, m_axis_tready = 1'b0;
  logic d1_din_valid = 1'b0, d1_flush = 1'b0, d1_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata, d1_tdata;
  logic din_ready, m_axis_tvalid, m_axis_tlast, busy, pkt_sent;
  logic d1_din_ready, d1_tvalid, d1_tlast, d1_busy, d1_pkt_sent;
  int vec = 0, bad = 0;
  logic [DW-1:0] fillq[$], outq[$];
  logic [DW:0] got[$];
  bit dead = 1'b1, exp_sent = 1'b0;

  fifo2axis #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .pkt_sent(pkt_sent));

  fifo2axis #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(d1_din), .din_valid(d1_din_valid), .din_ready(d1_din_ready),
    .flush(d1_flush), .m_axis_tdata(d1_tdata), .m_axis_tvalid(d1_tvalid),
    .m_axis_tready(d1_tready), .m_axis_tlast(d1_tlast), .busy(d1_busy), .pkt_sent(d1_pkt_sent));

  always #5 clk = ~clk;

  task automatic cyc(input bit dv, input logic [DW-1:0] d, input bit fl, input bit rdy);
    bit ev, er, el;
    logic [DW-1:0] ed;
    ev = outq.size() > 0;
    er = !dead && !ev;
    el = ev && outq.size() == 1;
    ed = '0;
    if (ev) ed = outq[0];
    vec++; if (din_ready !== er) begin bad++; $display("FAIL din_ready got=%b exp=%b t=%0t", din_ready, er, $time); end
    vec++; if (m_axis_tvalid !== ev) begin bad++; $display("FAIL tvalid got=%b exp=%b t=%0t", m_axis_tvalid, ev, $time); end
    vec++; if (m_axis_tdata !== ed) begin bad++; $display("FAIL tdata got=%h exp=%h t=%0t", m_axis_tdata, ed, $time); end
    vec++; if (m_axis_tlast !== el) begin bad++; $display("FAIL tlast got=%b exp=%b t=%0t", m_axis_tlast, el, $time); end
    vec++; if (busy !== ev) begin bad++; $display("FAIL busy got=%b exp=%b t=%0t", busy, ev, $time); end
    vec++; if (pkt_sent !== exp_sent) begin bad++; $display("FAIL pkt_sent got=%b exp=%b t=%0t", pkt_sent, exp_sent, $time); end
    din = d; din_valid = dv; flush = fl; m_axis_tready = rdy;
    if (m_axis_tvalid && rdy) got.push_back({m_axis_tlast, m_axis_tdata});
    exp_sent = ev && rdy && outq.size() == 1;
    if (dead) dead = 1'b0;
    else if (ev) begin
      if (rdy) void'(outq.pop_front());
    end else begin
      if (dv) fillq.push_back(d);
      if (fillq.size() == PL || (fl && fillq.size() > 0)) begin
        outq = fillq;
        fillq.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 80 && (outq.size() > 0 || exp_sent); i++) cyc(1'b0, '0, 1'b0, rnd ? 1'($urandom % 2) : 1'b1);
    vec++; if (outq.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d exp=0", outq.size()); end
  endtask

  task automatic model_reset();
    fillq.delete(); outq.delete(); got.delete();
    dead = 1'b1; exp_sent = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++; if ({m_axis_tvalid, m_axis_tlast, pkt_sent, din_ready, busy} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {m_axis_tvalid, m_axis_tlast, pkt_sent, din_ready, busy}); end
    vec++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_full_packet();
    logic [DW-1:0] e[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    got.delete();
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, e[i], 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    drain(1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    vec++; if (got.size() != 4) begin bad++; $display("FAIL full_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vec++; if (got[i] !== {i == 3, e[i]}) begin bad++; $display("FAIL full_beat%0d got=%h exp=%h", i, got[i], {i == 3, e[i]}); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    got.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, e[i], 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b0, pat[i]);
    drain(1'b0);
    vec++; if (got.size() != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vec++; if (got[i] !== {i == 3, e[i]}) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], {i == 3, e[i]}); end
    end
  endtask

  task automatic test_flush();
    got.delete();
    cyc(1'b1, 32'hA1, 1'b0, 1'b1);
    cyc(1'b1, 32'hA2, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    drain(1'b0);
    vec++; if (got.size() != 2 || got[0] !== {1'b0, 32'hA1} || got[1] !== {1'b1, 32'hA2}) begin bad++; $display("FAIL flush2 got_n=%0d exp=A1,A2(last)", got.size()); end
    got.delete();
    cyc(1'b1, 32'hB1, 1'b1, 1'b1);
    drain(1'b0);
    vec++; if (got.size() != 1 || got[0] !== {1'b1, 32'hB1}) begin bad++; $display("FAIL flush1 got_n=%0d exp=B1(last)", got.size()); end
  endtask

  task automatic test_drop();
    got.delete();
    cyc(1'b0, '0, 1'b1, 1'b1);
    vec++; if (m_axis_tvalid !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL empty_flush got=%b%b exp=01", m_axis_tvalid, din_ready); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0 + DW'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b1, 1'b1);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    drain(1'b0);
    vec++; if (got.size() != 4) begin bad++; $display("FAIL drop_count got=%0d exp=4", got.size()); end
    foreach (got[i]) begin
      vec++; if (got[i][DW-1:0] === 32'hDEAD) begin bad++; $display("FAIL drop_leak beat%0d got=%h exp=not DEAD", i, got[i]); end
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e[4] = '{32'h01, 32'h02, 32'h03, 32'h04};
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE0 + DW'(i), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    vec++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b00 || m_axis_tdata !== '0) begin bad++; $display("FAIL async_reset got=%b%b/%h exp=00/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, e[i], 1'b0, 1'b1);
    drain(1'b0);
    vec++; if (got.size() != 4) begin bad++; $display("FAIL post_reset_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vec++; if (got[i] !== {i == 3, e[i]}) begin bad++; $display("FAIL post_reset_beat%0d got=%h exp=%h", i, got[i], {i == 3, e[i]}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 4 != 0), DW'($urandom), 1'($urandom % 8 == 0), 1'($urandom % 3 != 0));
    drain(1'b1);
  endtask

  task automatic test_len1();
    logic [DW-1:0] d;
    int w;
    for (int k = 0; k < 6; k++) begin
      d = DW'($urandom);
      w = 0;
      while (d1_din_ready !== 1'b1 && w < 5) begin @(posedge clk); #1; w++; end
      vec++; if (d1_din_ready !== 1'b1) begin bad++; $display("FAIL len1_ready_timeout got=%b exp=1", d1_din_ready); end
      d1_din = d; d1_din_valid = 1'b1; d1_tready = 1'b0;
      @(posedge clk); #1;
      d1_din_valid = 1'b0;
      vec++; if ({d1_tvalid, d1_tlast, d1_din_ready, d1_busy} !== 4'b1101 || d1_tdata !== d) begin bad++; $display("FAIL len1_beat got=%b/%h exp=1101/%h", {d1_tvalid, d1_tlast, d1_din_ready, d1_busy}, d1_tdata, d); end
      for (int h = 0; h < k % 3; h++) begin
        @(posedge clk); #1;
        vec++; if (d1_tvalid !== 1'b1 || d1_tdata !== d) begin bad++; $display("FAIL len1_hold got=%b/%h exp=1/%h", d1_tvalid, d1_tdata, d); end
      end
      d1_tready = 1'b1;
      @(posedge clk); #1;
      d1_tready = 1'b0;
      vec++; if ({d1_tvalid, d1_pkt_sent, d1_din_ready} !== 3'b011 || d1_tdata !== '0) begin bad++; $display("FAIL len1_done got=%b/%h exp=011/0", {d1_tvalid, d1_pkt_sent, d1_din_ready}, d1_tdata); end
      @(posedge clk); #1;
      vec++; if (d1_pkt_sent !== 1'b0) begin bad++; $display("FAIL len1_pulse got=%b exp=0", d1_pkt_sent); end
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_backpressure();
    test_flush();
    test_drop();
    test_reset_mid();
    test_random();
    test_len1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
